// File: rtl/video_stream_out_stage.sv
// video_stream_out_stage
// Avalon-ST source stage behind the video effects block. Carries sop/eop of each
// accepted beat through a tag pipe matching the effects latency, checks frame
// framing on the processed pixel, and buffers the result in a credit-controlled
// first-word-fall-through FIFO so downstream backpressure never loses pixels.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   snk_valid/sop/eop          upstream beat (same cycle the pixel enters effects)
//   snk_ready                  upstream may transfer (credit: FIFO + in-flight)
//   proc_data                  processed pixel, LATENCY cycles after its beat
//   src_data/valid/sop/eop     Avalon-ST source towards the output DMA
//   src_ready                  downstream ready
//   frame_done                 pulse when the last pixel of a frame is written
//   frame_err                  pulse on a framing error (early eop, sop mid-frame)
//   drop_cnt                   saturating count of beats dropped outside a frame
module video_stream_out_stage #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FRAME_W    = 320,
    parameter int unsigned FRAME_H    = 240
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              snk_valid,
    input  logic              snk_sop,
    input  logic              snk_eop,
    output logic              snk_ready,
    input  logic [DATA_W-1:0] proc_data,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    output logic              src_sop,
    output logic              src_eop,
    input  logic              src_ready,
    output logic              frame_done,
    output logic              frame_err,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned FRAME_PIX = FRAME_W * FRAME_H;
    localparam int unsigned PCNT_W    = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int unsigned ADDR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W     = ADDR_W + 1;
    localparam int unsigned CRED_W    = $clog2(FIFO_DEPTH + LATENCY + 1);
    localparam logic [PCNT_W-1:0] LAST_PIX = PCNT_W'(FRAME_PIX - 1);

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    logic               accept;
    logic [LATENCY-1:0] tag_v;
    logic [LATENCY-1:0] tag_sop;
    logic [LATENCY-1:0] tag_eop;
    logic               tag_out_v;
    logic               tag_out_sop;
    logic               tag_out_eop;
    logic [CRED_W-1:0]  inflight;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   fifo_count;
    fifo_entry_t        mem [FIFO_DEPTH];
    fifo_entry_t        rd_entry;
    fifo_entry_t        wr_entry;
    logic               push;
    logic               pop;

    state_t             state_q;
    state_t             state_d;
    logic [PCNT_W-1:0]  pcnt_q;
    logic [PCNT_W-1:0]  pcnt_d;
    logic               done_d;
    logic               err_d;
    logic [15:0]        drop_d;

    // Credit check: every beat in flight already owns a FIFO slot
    assign accept     = snk_valid & snk_ready;
    assign fifo_count = wr_ptr - rd_ptr;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CRED_W'(tag_v[i]);
        end
    end

    assign snk_ready = reset & ((CRED_W'(fifo_count) + inflight) < CRED_W'(FIFO_DEPTH));

    // Tag pipe: last stage lines up with proc_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v   <= '0;
            tag_sop <= '0;
            tag_eop <= '0;
        end else begin
            tag_v[0]   <= accept;
            tag_sop[0] <= accept & snk_sop;
            tag_eop[0] <= accept & snk_eop;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_sop[i] <= tag_sop[i-1];
                tag_eop[i] <= tag_eop[i-1];
            end
        end
    end

    assign tag_out_v   = tag_v[LATENCY-1];
    assign tag_out_sop = tag_sop[LATENCY-1];
    assign tag_out_eop = tag_eop[LATENCY-1];

    // Framing next-state and write decode
    always_comb begin
        state_d       = state_q;
        pcnt_d        = pcnt_q;
        push          = 1'b0;
        wr_entry.sop  = 1'b0;
        wr_entry.eop  = 1'b0;
        wr_entry.data = proc_data;
        done_d        = 1'b0;
        err_d         = 1'b0;
        drop_d        = drop_cnt;
        if (tag_out_v) begin
            case (state_q)
                IDLE: begin
                    if (tag_out_sop) begin
                        push         = 1'b1;
                        wr_entry.sop = 1'b1;
                        if (FRAME_PIX == 1) begin
                            wr_entry.eop = 1'b1;
                            done_d       = 1'b1;
                        end else begin
                            pcnt_d  = PCNT_W'(1);
                            state_d = IN_FRAME;
                        end
                    end else if (drop_cnt != 16'hFFFF) begin
                        drop_d = drop_cnt + 16'd1;
                    end
                end
                IN_FRAME: begin
                    push = 1'b1;
                    if (tag_out_sop) begin
                        // Restart: the new sop begins a fresh frame
                        err_d        = 1'b1;
                        wr_entry.sop = 1'b1;
                        pcnt_d       = PCNT_W'(1);
                    end else if (pcnt_q == LAST_PIX) begin
                        wr_entry.eop = 1'b1;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                    end else if (tag_out_eop) begin
                        wr_entry.eop = 1'b1;
                        err_d        = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Framing state, pulses and drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            frame_done <= done_d;
            frame_err  <= err_d;
            drop_cnt   <= drop_d;
        end
    end

    // FIFO storage (contents need no reset; reads are masked when empty)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // First-word fall-through read side
    assign rd_entry  = mem[rd_ptr[ADDR_W-1:0]];
    assign src_valid = (fifo_count != '0);
    assign pop       = src_valid & src_ready;
    assign src_data  = src_valid ? rd_entry.data : '0;
    assign src_sop   = src_valid & rd_entry.sop;
    assign src_eop   = src_valid & rd_entry.eop;

endmodule

// File: tb/tb_video_stream_out_stage.sv
// Bench for video_stream_out_stage (FRAME_W=4, FRAME_H=2, LATENCY=1, FIFO_DEPTH=8).
// A transaction-level model turns the sequence of accepted beats into expected
// output words, pulses and drop counts, each stamped with the cycle it must appear.
module tb_video_stream_out_stage;

    localparam int unsigned DW    = 16;
    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FW    = 4;
    localparam int unsigned FH    = 2;
    localparam int          PIX   = FW * FH;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          snk_valid = 1'b0;
    logic          snk_sop = 1'b0;
    logic          snk_eop = 1'b0;
    logic          snk_ready;
    logic [DW-1:0] proc_data = '0;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_sop;
    logic          src_eop;
    logic          src_ready = 1'b0;
    logic          frame_done;
    logic          frame_err;
    logic [15:0]   drop_cnt;

    video_stream_out_stage #(
        .DATA_W(DW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .FRAME_W(FW), .FRAME_H(FH)
    ) dut (
        .clk(clk), .reset(reset),
        .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_ready(snk_ready),
        .proc_data(proc_data),
        .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_ready(src_ready),
        .frame_done(frame_done), .frame_err(frame_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
        int            vis;
    } exp_t;

    exp_t exp_q[$];
    exp_t out_log[$];
    int   done_q[$];
    int   err_q[$];
    int   drop_q[$];

    bit   m_in_frame = 1'b0;
    int   m_idx = 0;
    int   exp_drop = 0;
    int   last_acc_cyc = -100;
    int   first_acc_cyc = 0;
    int   obs_done = 0;
    int   obs_err = 0;
    bit   hold = 1'b1;
    bit   pend_v = 1'b0;
    logic [DW-1:0] pend_pix = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_word(input logic s, input logic e, input logic [DW-1:0] d, input int t);
        exp_t w;
        w.sop = s; w.eop = e; w.data = d; w.vis = t;
        exp_q.push_back(w);
    endtask

    // Framing rules applied to one accepted beat; effects appear LAT+1 cycles later
    task automatic model_accept(input logic s, input logic e, input logic [DW-1:0] d);
        int t;
        t = cyc + LAT + 1;
        last_acc_cyc = cyc;
        if (!m_in_frame) begin
            if (s) begin
                model_word(1'b1, PIX == 1, d, t);
                if (PIX == 1) done_q.push_back(t);
                else begin m_in_frame = 1'b1; m_idx = 1; end
            end else begin
                drop_q.push_back(t);
            end
        end else if (s) begin
            err_q.push_back(t);
            model_word(1'b1, 1'b0, d, t);
            m_idx = 1;
        end else if (m_idx == PIX - 1) begin
            model_word(1'b0, 1'b1, d, t);
            done_q.push_back(t);
            m_in_frame = 1'b0;
        end else if (e) begin
            model_word(1'b0, 1'b1, d, t);
            err_q.push_back(t);
            m_in_frame = 1'b0;
        end else begin
            model_word(1'b0, 1'b0, d, t);
            m_idx++;
        end
    endtask

    // Per-cycle compare of every DUT output against the model
    initial begin : compare
        bit   ev;
        bit   edone;
        bit   eerr;
        int   occ;
        exp_t w;
        forever begin
            @(negedge clk);
            if (!hold && reset) begin
                while (drop_q.size() > 0 && drop_q[0] <= cyc) begin
                    void'(drop_q.pop_front());
                    if (exp_drop < 65535) exp_drop++;
                end
                edone = (done_q.size() > 0 && done_q[0] == cyc);
                if (edone) void'(done_q.pop_front());
                eerr = (err_q.size() > 0 && err_q[0] == cyc);
                if (eerr) void'(err_q.pop_front());
                ev = (exp_q.size() > 0 && exp_q[0].vis <= cyc);
                occ = 0;
                foreach (exp_q[i]) if (exp_q[i].vis <= cyc) occ++;
                if (last_acc_cyc == cyc - 1) occ++;
                w.sop = 1'b0; w.eop = 1'b0; w.data = '0; w.vis = 0;
                if (ev) w = exp_q[0];
                chk("snk_ready", snk_ready, occ < DEPTH);
                chk("src_valid", src_valid, ev);
                chk("src_data", src_data, w.data);
                chk("src_sop", src_sop, w.sop);
                chk("src_eop", src_eop, w.eop);
                chk("frame_done", frame_done, edone);
                chk("frame_err", frame_err, eerr);
                chk("drop_cnt", drop_cnt, exp_drop);
                chk("no_full_write", (dut.push && dut.fifo_count == DEPTH), 0);
                if (frame_done) obs_done++;
                if (frame_err) obs_err++;
                if (src_valid && src_ready && ev) begin
                    w.vis = cyc;
                    out_log.push_back(w);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; also plays the effects block by echoing the pixel
    task automatic cycle(input bit v, input bit s, input bit e, input logic [DW-1:0] pix,
                         input bit rdy, output bit acc);
        @(posedge clk); #1;
        proc_data = pend_v ? pend_pix : DW'($urandom);
        snk_valid = v; snk_sop = s; snk_eop = e; src_ready = rdy;
        @(negedge clk); #2;
        acc = snk_valid && snk_ready && reset;
        if (acc) model_accept(s, e, pix);
        pend_v = acc;
        pend_pix = pix;
    endtask

    task automatic send_frame(input int n, input bit with_sop, input int eop_at,
                              input int base, input bit rdy);
        bit acc;
        int tries;
        for (int i = 0; i < n; i++) begin
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 50) begin
                cycle(1'b1, with_sop && i == 0, i == eop_at, DW'(base + i), rdy, acc);
                tries++;
            end
            if (!acc) chk("send_timeout", 0, 1);
            if (i == 0) first_acc_cyc = cyc;
        end
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, acc);
        chk("drain_left", exp_q.size(), 0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, acc);
    endtask

    task automatic start_test();
        out_log.delete();
        obs_done = 0;
        obs_err = 0;
    endtask

    initial begin : main
        bit acc;
        int n;
        int gidx;
        int r;
        bit v, s, e;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_src_valid", src_valid, 0);
        chk("rst_snk_ready", snk_ready, 0);
        chk("rst_src_data", src_data, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_frame_done", frame_done, 0);
        @(negedge clk); #1;
        reset = 1'b1;
        hold = 1'b0;

        // 1: clean frame, data = index
        start_test();
        send_frame(PIX, 1'b1, PIX - 1, 0, 1'b1);
        drain();
        chk("t1_words", out_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < out_log.size()) begin
                chk($sformatf("t1_data%0d", i), out_log[i].data, i);
                chk($sformatf("t1_sop%0d", i), out_log[i].sop, i == 0);
                chk($sformatf("t1_eop%0d", i), out_log[i].eop, i == 7);
            end
        end
        if (out_log.size() > 0) chk("t1_first_valid", out_log[0].vis, first_acc_cyc + 2);
        chk("t1_done", obs_done, 1);
        chk("t1_err", obs_err, 0);

        // 2: backpressure fills the FIFO through the credit limit
        start_test();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, n == 0, 1'b0, DW'(100 + n), 1'b0, acc);
            if (!acc) break;
            n++;
        end
        chk("t2_accepted", n, 8);
        drain();
        chk("t2_words", out_log.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < out_log.size()) chk($sformatf("t2_data%0d", i), out_log[i].data, 100 + i);

        // 3: no upstream eop, eop forced on 8th pixel
        start_test();
        send_frame(PIX, 1'b1, -1, 200, 1'b1);
        drain();
        chk("t3_words", out_log.size(), 8);
        if (out_log.size() == 8) begin
            chk("t3_eop7", out_log[7].eop, 1);
            chk("t3_eop6", out_log[6].eop, 0);
        end
        chk("t3_err", obs_err, 0);
        chk("t3_done", obs_done, 1);

        // 4: early eop on beat 5, then a clean frame
        start_test();
        send_frame(5, 1'b1, 4, 400, 1'b1);
        drain();
        chk("t4_words", out_log.size(), 5);
        if (out_log.size() == 5) chk("t4_eop4", out_log[4].eop, 1);
        chk("t4_err", obs_err, 1);
        chk("t4_done", obs_done, 0);
        start_test();
        send_frame(PIX, 1'b1, PIX - 1, 500, 1'b1);
        drain();
        chk("t4b_words", out_log.size(), 8);
        chk("t4b_err", obs_err, 0);
        chk("t4b_done", obs_done, 1);

        // 5: three orphan beats are dropped
        start_test();
        send_frame(3, 1'b0, -1, 600, 1'b1);
        send_frame(PIX, 1'b1, PIX - 1, 700, 1'b1);
        drain();
        chk("t5_drop", drop_cnt, 3);
        chk("t5_words", out_log.size(), 8);

        // 6: reset with 5 words buffered mid-frame
        start_test();
        send_frame(5, 1'b1, -1, 800, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);
        chk("t6_fifo_valid", src_valid, 1);
        @(posedge clk); #3;
        hold = 1'b1;
        reset = 1'b0;
        #1;
        chk("t6_valid_in_reset", src_valid, 0);
        chk("t6_ready_in_reset", snk_ready, 0);
        chk("t6_drop_in_reset", drop_cnt, 0);
        snk_valid = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete(); done_q.delete(); err_q.delete(); drop_q.delete();
        m_in_frame = 1'b0; m_idx = 0; exp_drop = 0;
        pend_v = 1'b0; last_acc_cyc = -100;
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("t6_ready_after", snk_ready, 1);
        chk("t6_valid_after", src_valid, 0);
        hold = 1'b0;
        start_test();
        send_frame(1, 1'b0, -1, 900, 1'b1);
        drain();
        chk("t6_idle_drop", drop_cnt, 1);
        chk("t6_no_words", out_log.size(), 0);

        // Random traffic with occasional framing faults and backpressure
        start_test();
        gidx = 0;
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 99));
            v = ($urandom_range(0, 9) < 7);
            s = (gidx == 0 && r >= 6) || (r < 3);
            e = (gidx == PIX - 1) || (r >= 97);
            cycle(v, s, e, DW'($urandom), $urandom_range(0, 9) < 6, acc);
            if (acc) gidx = s ? 1 : (gidx + 1) % PIX;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
